// File: rtl/stage_mem.sv
// Memory-access stage: drives the req/gnt/rvalid data port, aligns load data, builds store
// lanes, stalls the pipe while an access is outstanding and holds the MEM/WB register.
module stage_mem #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ex_valid,
    input  logic [XLEN-1:0]     ex_alu_result,
    input  logic [XLEN-1:0]     ex_store_data,
    input  logic [4:0]          ex_rd_addr,
    input  logic                ex_reg_write,
    input  logic [1:0]          ex_wb_src,
    input  logic [PC_WIDTH-1:0] ex_pc_plus_4,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [2:0]          ex_funct3,

    output logic                mem_stall,
    output logic                mem_misaligned,

    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,

    output logic [XLEN-1:0]     wb_alu_result,
    output logic [XLEN-1:0]     wb_mem_data,
    output logic [4:0]          wb_rd_addr,
    output logic                wb_reg_write,
    output logic [1:0]          wb_wb_src,
    output logic                wb_valid,
    output logic [PC_WIDTH-1:0] wb_pc_plus_4
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitGnt,
        StWaitRvalid
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]     wb_alu_result_q, wb_alu_result_d;
    logic [XLEN-1:0]     wb_mem_data_q,   wb_mem_data_d;
    logic [4:0]          wb_rd_addr_q,    wb_rd_addr_d;
    logic                wb_reg_write_q,  wb_reg_write_d;
    logic [1:0]          wb_wb_src_q,     wb_wb_src_d;
    logic                wb_valid_q,      wb_valid_d;
    logic [PC_WIDTH-1:0] wb_pc_plus_4_q,  wb_pc_plus_4_d;

    logic [1:0]      offset;
    logic [1:0]      size;
    logic            mem_op;
    logic            misaligned;
    logic            issue_phase;
    logic            req;
    logic            mis_pulse;
    logic            store_done;
    logic            load_done;
    logic            retire;
    logic [XLEN-1:0] rdata_shift;
    logic [XLEN-1:0] load_data;

    assign offset = ex_alu_result[1:0];
    assign size   = ex_funct3[1:0];
    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            default: misaligned = |offset;
        endcase
    end

    // Request phase covers IDLE and WAIT_GNT; upstream holds ex_* stable while stalled,
    // so the combinational request fields stay stable until the grant.
    assign issue_phase = (state_q == StIdle) || (state_q == StWaitGnt);
    assign req         = issue_phase & mem_op & ~misaligned;
    assign mis_pulse   = (state_q == StIdle) & mem_op & misaligned;
    assign store_done  = req & dmem_gnt & ex_mem_write;
    assign load_done   = (state_q == StWaitRvalid) & dmem_rvalid;
    assign retire      = ~mem_op | mis_pulse | store_done | load_done;

    assign mem_stall      = mem_op & ~retire;
    assign mem_misaligned = mis_pulse;
    assign dmem_req       = req;
    assign dmem_we        = ex_mem_write;
    assign dmem_addr      = {ex_alu_result[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = ex_store_data;
        unique case (size)
            2'b00: begin
                dmem_be    = 4'b0001 << offset;
                dmem_wdata = {(XLEN/8){ex_store_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << offset;
                dmem_wdata = {(XLEN/16){ex_store_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = ex_store_data;
            end
        endcase
    end

    assign rdata_shift = dmem_rdata >> {offset, 3'b000};

    always_comb begin
        load_data = rdata_shift;
        case (ex_funct3)
            3'b000:  load_data = {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, rdata_shift[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StWaitGnt: begin
                state_d = StIdle;
                if (req) begin
                    if (!dmem_gnt) begin
                        state_d = StWaitGnt;
                    end else if (!ex_mem_write) begin
                        state_d = StWaitRvalid;
                    end
                end
            end
            StWaitRvalid: begin
                if (dmem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Any cycle that does not retire a live instruction writes an all-zero bubble.
    always_comb begin
        wb_alu_result_d = '0;
        wb_mem_data_d   = '0;
        wb_rd_addr_d    = '0;
        wb_reg_write_d  = 1'b0;
        wb_wb_src_d     = '0;
        wb_valid_d      = 1'b0;
        wb_pc_plus_4_d  = '0;
        if (retire && ex_valid) begin
            wb_alu_result_d = ex_alu_result;
            wb_mem_data_d   = load_done ? load_data : '0;
            wb_rd_addr_d    = ex_rd_addr;
            wb_reg_write_d  = ex_reg_write & ~mis_pulse;
            wb_wb_src_d     = ex_wb_src;
            wb_valid_d      = 1'b1;
            wb_pc_plus_4_d  = ex_pc_plus_4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            wb_alu_result_q <= '0;
            wb_mem_data_q   <= '0;
            wb_rd_addr_q    <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_wb_src_q     <= '0;
            wb_valid_q      <= 1'b0;
            wb_pc_plus_4_q  <= '0;
        end else begin
            state_q         <= state_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_mem_data_q   <= wb_mem_data_d;
            wb_rd_addr_q    <= wb_rd_addr_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_wb_src_q     <= wb_wb_src_d;
            wb_valid_q      <= wb_valid_d;
            wb_pc_plus_4_q  <= wb_pc_plus_4_d;
        end
    end

    assign wb_alu_result = wb_alu_result_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign wb_rd_addr    = wb_rd_addr_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_wb_src     = wb_wb_src_q;
    assign wb_valid      = wb_valid_q;
    assign wb_pc_plus_4  = wb_pc_plus_4_q;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios plus randomized op sequences checked against an
// arithmetic model of size/offset/sign rules and request/stall timing.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_alu_result, ex_store_data, ex_pc_plus_4;
    logic [4:0]  ex_rd_addr;
    logic [1:0]  ex_wb_src;
    logic [2:0]  ex_funct3;
    logic        mem_stall, mem_misaligned, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] wb_alu_result, wb_mem_data, wb_pc_plus_4;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write, wb_valid;
    logic [1:0]  wb_wb_src;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stage_mem #(.XLEN(32), .PC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_wb_src(ex_wb_src),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_wb_src(wb_wb_src),
        .wb_valid(wb_valid), .wb_pc_plus_4(wb_pc_plus_4)
    );

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word,
                                               input int off);
        longint unsigned v;
        v = longint'(word) / (longint'(1) << (8 * off));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = v % (longint'(1) << 32);
        endcase
        return v[31:0];
    endfunction

    task automatic clear_inputs();
        ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_alu_result = 0; ex_store_data = 0; ex_pc_plus_4 = 0; ex_rd_addr = 0;
        ex_wb_src = 0; ex_funct3 = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    // Drives one instruction through MEM, answering the memory port after gdly/rdly cycles.
    task automatic run_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int gdly, input int rdly);
        logic        memop, mis, regw, exp_req, exp_stall;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] pc4, exp_addr, exp_wdata, exp_ld;
        logic [3:0]  exp_be;
        int          off, sz, ncyc;
        rd = 5'($urandom); src = 2'($urandom % 3); pc4 = $urandom; regw = 1'($urandom);
        memop = v && (ld || st);
        off = int'(addr % 4);
        sz = int'(f3 % 4);
        mis = memop && ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0));
        ncyc = (!memop || mis) ? 1 : (st ? gdly + 1 : gdly + rdly + 1);
        exp_addr = (addr / 4) * 4;
        exp_be = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
        exp_wdata = (sz == 0) ? (sdata % 256) * 32'h0101_0101 :
                    (sz == 1) ? (sdata % 65536) * 32'h0001_0001 : sdata;
        exp_ld = model_load(f3, rdata, off);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                ex_valid = v; ex_mem_read = ld; ex_mem_write = st; ex_funct3 = f3;
                ex_alu_result = addr; ex_store_data = sdata; ex_rd_addr = rd;
                ex_wb_src = src; ex_pc_plus_4 = pc4; ex_reg_write = regw;
            end
            dmem_rdata = $urandom;
            dmem_gnt = memop && !mis && c == gdly;
            dmem_rvalid = 1'b0;
            if (memop && !mis && c < gdly) dmem_rvalid = 1'($urandom);
            if (!memop || mis) dmem_rvalid = 1'($urandom);
            if (memop && !mis && ld && !st && c == gdly + rdly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            exp_req = memop && !mis && c <= gdly;
            exp_stall = memop && !mis && c != ncyc - 1;
            total++;
            if (dmem_req !== exp_req) begin
                bad++; $display("FAIL dmem_req cyc%0d: got %b want %b", c, dmem_req, exp_req);
            end
            total++;
            if (mem_stall !== exp_stall) begin
                bad++; $display("FAIL mem_stall cyc%0d: got %b want %b", c, mem_stall, exp_stall);
            end
            total++;
            if (mem_misaligned !== (mis && c == 0)) begin
                bad++; $display("FAIL mem_misaligned cyc%0d: got %b want %b", c, mem_misaligned,
                                mis && c == 0);
            end
            if (exp_req) begin
                total++;
                if (dmem_addr !== exp_addr || dmem_be !== exp_be || dmem_we !== st) begin
                    bad++; $display("FAIL req_fields: got addr=%h be=%b we=%b want %h %b %b",
                                    dmem_addr, dmem_be, dmem_we, exp_addr, exp_be, st);
                end
                if (st) begin
                    total++;
                    if (dmem_wdata !== exp_wdata) begin
                        bad++; $display("FAIL dmem_wdata: got %h want %h", dmem_wdata, exp_wdata);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (c < ncyc - 1) begin
                total++;
                if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin
                    bad++; $display("FAIL bubble: got valid=%b rw=%b want 0 0", wb_valid,
                                    wb_reg_write);
                end
            end else begin
                total++;
                if (wb_valid !== v || wb_reg_write !== (v && regw && !mis)) begin
                    bad++; $display("FAIL wb_ctrl: got valid=%b rw=%b want %b %b", wb_valid,
                                    wb_reg_write, v, v && regw && !mis);
                end
                if (v) begin
                    total++;
                    if (wb_alu_result !== addr || wb_rd_addr !== rd || wb_wb_src !== src ||
                        wb_pc_plus_4 !== pc4) begin
                        bad++; $display("FAIL wb_fields: got %h %0d %0d %h want %h %0d %0d %h",
                                        wb_alu_result, wb_rd_addr, wb_wb_src, wb_pc_plus_4,
                                        addr, rd, src, pc4);
                    end
                end
                if (memop && !mis && ld && !st) begin
                    total++;
                    if (wb_mem_data !== exp_ld) begin
                        bad++; $display("FAIL wb_mem_data: got %h want %h", wb_mem_data, exp_ld);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        total++;
        if (mem_stall !== 0 || mem_misaligned !== 0 || dmem_req !== 0) begin
            bad++; $display("FAIL reset_ctrl: got stall=%b mis=%b req=%b want 0 0 0",
                            mem_stall, mem_misaligned, dmem_req);
        end
        total++;
        if (wb_valid !== 0 || wb_reg_write !== 0 || wb_alu_result !== 0 || wb_mem_data !== 0 ||
            wb_rd_addr !== 0 || wb_wb_src !== 0 || wb_pc_plus_4 !== 0) begin
            bad++; $display("FAIL reset_wb: got valid=%b rw=%b alu=%h mem=%h want all 0",
                            wb_valid, wb_reg_write, wb_alu_result, wb_mem_data);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_alu();
        run_op(1, 0, 0, 3'b010, 32'h1234, 0, 0, 0, 1);
        total++;
        if (wb_alu_result !== 32'h1234) begin
            bad++; $display("FAIL alu_result: got %h want 00001234", wb_alu_result);
        end
    endtask

    task automatic test_lb_sign();
        run_op(1, 1, 0, 3'b000, 32'h103, 0, 32'h80FF_FF7F, 0, 1);
        total++;
        if (wb_mem_data !== 32'hFFFF_FF80) begin
            bad++; $display("FAIL lb_data: got %h want ffffff80", wb_mem_data);
        end
    endtask

    task automatic test_sh_delayed();
        run_op(1, 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 3, 1);
    endtask

    task automatic test_misaligned();
        run_op(1, 1, 0, 3'b010, 32'h6, 0, 32'hDEAD_BEEF, 0, 1);
        run_op(1, 0, 1, 3'b001, 32'h3, 32'h55, 0, 0, 1);
    endtask

    task automatic test_lhu();
        run_op(1, 1, 0, 3'b101, 32'h2, 0, 32'h8001_0000, 0, 1);
        total++;
        if (wb_mem_data !== 32'h0000_8001) begin
            bad++; $display("FAIL lhu_data: got %h want 00008001", wb_mem_data);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        clear_inputs();
        ex_valid = 1; ex_mem_read = 1; ex_funct3 = 3'b010; ex_alu_result = 32'h40;
        ex_reg_write = 1; ex_rd_addr = 5'd7; dmem_gnt = 1;
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        #1;
        total++;
        if (dmem_req !== 0 || mem_stall !== 0 || wb_valid !== 0) begin
            bad++; $display("FAIL midreset: got req=%b stall=%b valid=%b want 0 0 0",
                            dmem_req, mem_stall, wb_valid);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        total++;
        if (wb_valid !== 0 || wb_reg_write !== 0 || wb_mem_data !== 0 || wb_alu_result !== 0 ||
            wb_rd_addr !== 0 || wb_pc_plus_4 !== 0 || wb_wb_src !== 0) begin
            bad++; $display("FAIL stale_rvalid: got valid=%b rw=%b mem=%h want all 0",
                            wb_valid, wb_reg_write, wb_mem_data);
        end
        @(negedge clk);
        dmem_rvalid = 0;
    endtask

    task automatic test_random_back_to_back();
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind;
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom % 4);
            addr = $urandom;
            if (kind == 2) f3 = f3s[$urandom % 3];
            else f3 = f3s[$urandom % 5];
            if ($urandom % 4 != 0) begin
                if (f3[1:0] == 2'b01) addr = (addr / 2) * 2;
                if (f3[1:0] == 2'b10) addr = (addr / 4) * 4;
            end
            case (kind)
                0: run_op(1, 0, 0, f3, addr, $urandom, 0, 0, 1);
                1: run_op(1, 1, 0, f3, addr, 0, $urandom, $urandom % 4, 1 + $urandom % 3);
                2: run_op(1, 0, 1, f3, addr, $urandom, 0, $urandom % 4, 1);
                default: run_op(0, 1'($urandom), 1'($urandom), f3, addr, $urandom, 0, 0, 1);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_sign();
        test_sh_delayed();
        test_misaligned();
        test_lhu();
        test_reset_mid_access();
        test_random_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
